multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 reset_ni  input  1  synchronous active-low reset.
REQ-004 op_i6  input  6  opcode from the instruction register, bits [31:26].
REQ-005 funct_i6  input  6  function field, bits [5:0].
REQ-006 zero_i  input  1  ALU zero flag from the datapath.
REQ-007 mem_ready_i  input  1  memory access complete this cycle.
REQ-008 iord_o  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 mem_write_o  output  1  memory write enable.
REQ-010 ir_write_o  output  1  instruction register load enable.
REQ-011 reg_dst_o  output  1  register write address select: 0 = rt, 1 = rd.
REQ-012 mem_to_reg_o  output  1  register write data select: 0 = ALU result register, 1 = data register.
REQ-013 reg_write_o  output  1  register file write enable.
REQ-014 alu_src_a_o  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-015 alu_src_b_o2  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
REQ-016 alu_control_o3  output  3  ALU operation code.
REQ-017 pc_src_o2  output  2  PC next-value select: 00 = ALU result, 01 = ALU result register, 10 = jump target.
REQ-018 pc_en_o  output  1  PC load enable.
REQ-019 illegal_op_o  output  1  one-cycle pulse on an unsupported opcode.
REQ-020 state_o4  output  4  current state encoding, for debug.

Function
REQ-021 The block SHALL be a Moore FSM; all outputs are decoded from the state register, except pc_en_o and alu_control_o3.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-022 FETCH SHALL drive:
- iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00.
- ir_write and the PC write request asserted only while mem_ready_i=1.
- Stay in FETCH while mem_ready_i=0; go to DECODE when it is 1.
REQ-023 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=add, and branch on op_i6:
- lw (100011) or sw (101011) -> MEMADR.
- R-type (000000) -> EXECUTE.
- beq (000100) -> BRANCH.
- addi (001000) -> ADDIEX.
- j (000010) -> JUMP.
- Any other opcode -> FETCH with illegal_op_o=1 for that cycle.
REQ-024 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=add; next state is MEMRD for lw and MEMWR for sw.
REQ-025 MEMRD SHALL drive iord=1 and hold until mem_ready_i=1, then go to MEMWB.
- MEMWB SHALL drive reg_dst=0, mem_to_reg=1, reg_write=1, then go to FETCH.
REQ-026 MEMWR SHALL drive iord=1 and mem_write_o=1 every cycle until mem_ready_i=1, then go to FETCH.
REQ-027 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00, alu_op=funct, then go to ALUWB.
- ALUWB SHALL drive reg_dst=1, mem_to_reg=0, reg_write=1, then go to FETCH.
REQ-028 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01 and the branch request, then go to FETCH.
REQ-029 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=add, then go to ADDIWB.
- ADDIWB SHALL drive reg_dst=0, mem_to_reg=0, reg_write=1, then go to FETCH.
REQ-030 JUMP SHALL drive pc_src=10 and the PC write request, then go to FETCH.
REQ-031 pc_en_o SHALL equal pc_write OR (branch AND zero_i), and SHALL be forced to 0 while reset_ni=0.
REQ-032 alu_control_o3 SHALL be decoded combinationally:
- alu_op=add -> 010; alu_op=sub -> 110.
- alu_op=funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
REQ-033 With mem_ready_i held at 1, instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-034 Any state not listed in REQ-021 SHALL go to FETCH on the next edge, with all enables 0 in that cycle.

Reset
REQ-035 When reset_ni=0 at a rising edge, the state SHALL become FETCH, from any state, including a pending memory wait.
REQ-036 While reset_ni=0, these outputs SHALL be forced to 0: mem_write_o, ir_write_o, reg_write_o, pc_en_o, illegal_op_o. All other outputs remain state-decoded.

Configuration
REQ-037 With MC_BNE_EN defined:
- op 000101 in DECODE SHALL go to BRANCH.
- In that BRANCH cycle, pc_en_o SHALL equal NOT zero_i.
REQ-038 Without MC_BNE_EN, op 000101 SHALL be treated as illegal per REQ-023.

Verification
REQ-039 Reset: reset_ni=0 for 2 cycles from state MEMWR -> state_o4=0 and mem_write_o=0 during reset; FETCH on release.
REQ-040 lw, mem_ready_i=1: state trace 0,1,2,3,4,0; reg_write_o=1 only in state 4.
REQ-041 sw, mem_ready_i low for 3 cycles in MEMWR: mem_write_o=1 for 4 cycles, then FETCH.
REQ-042 beq with zero_i=1 -> pc_en_o=1 and pc_src_o2=01 in BRANCH; with zero_i=0 -> pc_en_o=0.
REQ-043 R-type funct 101010 -> alu_control_o3=111 in EXECUTE; op 111111 -> illegal_op_o pulses once, then FETCH.
REQ-044 With MC_BNE_EN: op 000101 and zero_i=0 -> pc_en_o=1 in BRANCH; without it -> illegal_op_o=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for a multicycle MIPS-style datapath (lw, sw, R-type, beq,
// addi, j). Moore FSM: every datapath select and enable comes from the
// current state. ir_write/PC-write in FETCH are qualified by mem_ready_i.
// illegal_op_o is qualified by the opcode in DECODE. pc_en_o and
// alu_control_o3 are combinational decodes.
//
// Optional feature: define MC_BNE_EN to add bne (opcode 000101). bne uses
// the BRANCH state and takes the branch when zero_i is 0.
//
// Ports
//   clk_i          clock, rising edge
//   reset_ni       synchronous active-low reset
//   op_i6          opcode, instruction bits [31:26]
//   funct_i6       function field, instruction bits [5:0]
//   zero_i         ALU zero flag
//   mem_ready_i    memory access completes this cycle
//   iord_o         memory address select (0 PC, 1 ALU result register)
//   mem_write_o    memory write enable
//   ir_write_o     instruction register load enable
//   reg_dst_o      register write address select (0 rt, 1 rd)
//   mem_to_reg_o   register write data select (0 ALU out, 1 data register)
//   reg_write_o    register file write enable
//   alu_src_a_o    ALU A select (0 PC, 1 register A)
//   alu_src_b_o2   ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   alu_control_o3 ALU operation code
//   pc_src_o2      PC source (00 ALU, 01 ALU out register, 10 jump target)
//   pc_en_o        PC load enable
//   illegal_op_o   one-cycle pulse on an unsupported opcode
//   state_o4       current state, for debug
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [5:0] op_i6,
  input  logic [5:0] funct_i6,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       iord_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o2,
  output logic [2:0] alu_control_o3,
  output logic [1:0] pc_src_o2,
  output logic       pc_en_o,
  output logic       illegal_op_o,
  output logic [3:0] state_o4
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_EXECUTE = 4'd6, S_ALUWB  = 4'd7,
    S_BRANCH  = 4'd8,  S_ADDIEX  = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t  state_r;
  state_t  state_next_s;
  alu_op_t alu_op_s;
  logic    pc_write_s;
  logic    branch_s;
  logic    branch_cond_s;
  logic    mem_write_s;
  logic    ir_write_s;
  logic    reg_write_s;
  logic    illegal_s;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and state-decoded control; unlisted encodings return to FETCH.
  always_comb begin
    state_next_s = S_FETCH;
    iord_o       = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o2 = 2'b00;
    alu_op_s     = ALU_ADD;
    pc_src_o2    = 2'b00;
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        alu_src_b_o2 = 2'b01;
        if (mem_ready_i) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target PC + (imm << 2) is computed speculatively here.
        alu_src_b_o2 = 2'b11;
        case (op_i6)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_RTYPE:     state_next_s = S_EXECUTE;
          OP_BEQ:       state_next_s = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       state_next_s = S_BRANCH;
`endif
          OP_ADDI:      state_next_s = S_ADDIEX;
          OP_J:         state_next_s = S_JUMP;
          default: begin
            illegal_s    = 1'b1;
            state_next_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
        state_next_s = (op_i6 == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_o = 1'b1;
        if (mem_ready_i) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        mem_to_reg_o = 1'b1;
        reg_write_s  = 1'b1;
      end
      S_MEMWR: begin
        iord_o      = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready_i) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEMWR;
        end
      end
      S_EXECUTE: begin
        alu_src_a_o  = 1'b1;
        alu_op_s     = ALU_FUNCT;
        state_next_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst_o   = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_s    = ALU_SUB;
        pc_src_o2   = 2'b01;
        branch_s    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
        state_next_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
      end
      S_JUMP: begin
        pc_src_o2  = 2'b10;
        pc_write_s = 1'b1;
      end
      default: begin
        state_next_s = S_FETCH;
      end
    endcase
  end

  // Branch condition: beq takes on zero, bne (when enabled) on not-zero.
  always_comb begin
    branch_cond_s = zero_i;
`ifdef MC_BNE_EN
    if (op_i6 == OP_BNE) begin
      branch_cond_s = ~zero_i;
    end else begin
      branch_cond_s = zero_i;
    end
`endif
  end

  // ALU operation decode from the FSM's ALU request and the funct field.
  always_comb begin
    alu_control_o3 = 3'b010;
    case (alu_op_s)
      ALU_ADD: alu_control_o3 = 3'b010;
      ALU_SUB: alu_control_o3 = 3'b110;
      ALU_FUNCT: begin
        case (funct_i6)
          6'b100000: alu_control_o3 = 3'b010;
          6'b100010: alu_control_o3 = 3'b110;
          6'b100100: alu_control_o3 = 3'b000;
          6'b100101: alu_control_o3 = 3'b001;
          6'b101010: alu_control_o3 = 3'b111;
          default:   alu_control_o3 = 3'b010;
        endcase
      end
      default: alu_control_o3 = 3'b010;
    endcase
  end

  // Side-effecting strobes are held off while reset is asserted.
  assign mem_write_o  = reset_ni & mem_write_s;
  assign ir_write_o   = reset_ni & ir_write_s;
  assign reg_write_o  = reset_ni & reg_write_s;
  assign illegal_op_o = reset_ni & illegal_s;
  assign pc_en_o      = reset_ni & (pc_write_s | (branch_s & branch_cond_s));
  assign state_o4     = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic [5:0] op_i6;
  logic [5:0] funct_i6;
  logic       zero_i;
  logic       mem_ready_i;
  logic       iord_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o;
  logic       reg_write_o, alu_src_a_o, pc_en_o, illegal_op_o;
  logic [1:0] alu_src_b_o2, pc_src_o2;
  logic [2:0] alu_control_o3;
  logic [3:0] state_o4;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

  multicycle_controller dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .op_i6(op_i6), .funct_i6(funct_i6),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .iord_o(iord_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o2(alu_src_b_o2),
    .alu_control_o3(alu_control_o3), .pc_src_o2(pc_src_o2), .pc_en_o(pc_en_o),
    .illegal_op_o(illegal_op_o), .state_o4(state_o4)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit is_legal(logic [5:0] op);
    return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) ||
           (op == ADDI) || (op == JMP) || (BNE_EN && op == BNE);
  endfunction

  function automatic logic [2:0] funct_alu(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Observed control word: state, then every output in port order.
  function automatic logic [19:0] actual_word();
    return {state_o4, iord_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
            reg_write_o, alu_src_a_o, alu_src_b_o2, alu_control_o3, pc_src_o2,
            pc_en_o, illegal_op_o};
  endfunction

  // Expected control word for a given step of an instruction.
  function automatic logic [19:0] expect_word(int st, logic [5:0] op, logic [5:0] f,
                                              logic z, logic rdy, logic rst_n);
    logic iord, mw, irw, rd, m2r, rw, a, pen, ill;
    logic [1:0] b, ps;
    logic [2:0] alu;
    logic [3:0] s4;
    iord = 1'b0; mw = 1'b0; irw = 1'b0; rd = 1'b0; m2r = 1'b0; rw = 1'b0;
    a = 1'b0; pen = 1'b0; ill = 1'b0; b = 2'b00; ps = 2'b00; alu = 3'b010;
    s4 = st[3:0];
    case (st)
      0:  begin b = 2'b01; irw = rdy; pen = rdy; end
      1:  begin b = 2'b11; ill = !is_legal(op); end
      2:  begin a = 1'b1; b = 2'b10; end
      3:  iord = 1'b1;
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin iord = 1'b1; mw = 1'b1; end
      6:  begin a = 1'b1; alu = funct_alu(f); end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin a = 1'b1; alu = 3'b110; ps = 2'b01;
                pen = (BNE_EN && op == BNE) ? !z : z; end
      9:  begin a = 1'b1; b = 2'b10; end
      10: rw = 1'b1;
      11: begin ps = 2'b10; pen = 1'b1; end
      default: ;
    endcase
    if (!rst_n) begin
      mw = 1'b0; irw = 1'b0; rw = 1'b0; pen = 1'b0; ill = 1'b0;
    end
    return {s4, iord, mw, irw, rd, m2r, rw, a, b, alu, ps, pen, ill};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one instruction from FETCH, checking every cycle against the step list
  // that the instruction's semantics imply (fw fetch waits, mw memory waits).
  task automatic run_instr(string name, logic [5:0] op, logic [5:0] f, logic z,
                           int fw, int mw);
    int   st_q[$];
    logic rdy_q[$];
    op_i6 = op; funct_i6 = f; zero_i = z;
    for (int i = 0; i < fw; i++) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
    st_q.push_back(0); rdy_q.push_back(1'b1);
    st_q.push_back(1); rdy_q.push_back(1'($urandom));
    if (op == LW || op == SW) begin
      st_q.push_back(2); rdy_q.push_back(1'($urandom));
      for (int i = 0; i < mw; i++) begin
        st_q.push_back(op == LW ? 3 : 5); rdy_q.push_back(1'b0);
      end
      st_q.push_back(op == LW ? 3 : 5); rdy_q.push_back(1'b1);
      if (op == LW) begin st_q.push_back(4); rdy_q.push_back(1'($urandom)); end
    end else if (op == RT) begin
      st_q.push_back(6); st_q.push_back(7);
      rdy_q.push_back(1'($urandom)); rdy_q.push_back(1'($urandom));
    end else if (op == ADDI) begin
      st_q.push_back(9); st_q.push_back(10);
      rdy_q.push_back(1'($urandom)); rdy_q.push_back(1'($urandom));
    end else if (op == BEQ || (BNE_EN && op == BNE)) begin
      st_q.push_back(8); rdy_q.push_back(1'($urandom));
    end else if (op == JMP) begin
      st_q.push_back(11); rdy_q.push_back(1'($urandom));
    end
    for (int i = 0; i < st_q.size(); i++) begin
      mem_ready_i = rdy_q[i];
      @(negedge clk_i);
      check(name, 32'(actual_word()),
            32'(expect_word(st_q[i], op, f, z, rdy_q[i], 1'b1)));
      @(posedge clk_i); #1;
    end
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    check({name, "_end"}, 32'(state_o4), 32'd0);
    @(posedge clk_i); #1;
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    int         len;
    int         pcen;
    int         ill;
    int         rw;
  } vec_t;

  vec_t vecs[10];
  logic [5:0] op_pool[9];
  logic [5:0] fn_pool[6];

  initial begin
    int cnt, pe, il, rw, wcnt;

    vecs[0] = '{LW,   6'b100000, 1'b0, 5, 1, 0, 1};
    vecs[1] = '{SW,   6'b100000, 1'b0, 4, 1, 0, 0};
    vecs[2] = '{RT,   6'b100000, 1'b0, 4, 1, 0, 1};
    vecs[3] = '{ADDI, 6'b000000, 1'b1, 4, 1, 0, 1};
    vecs[4] = '{BEQ,  6'b000000, 1'b1, 3, 2, 0, 0};
    vecs[5] = '{BEQ,  6'b000000, 1'b0, 3, 1, 0, 0};
    vecs[6] = '{JMP,  6'b000000, 1'b0, 3, 2, 0, 0};
    vecs[7] = '{BAD,  6'b000000, 1'b0, 2, 1, 1, 0};
    vecs[8] = '{BNE,  6'b000000, 1'b0, BNE_EN ? 3 : 2, BNE_EN ? 2 : 1, BNE_EN ? 0 : 1, 0};
    vecs[9] = '{BNE,  6'b000000, 1'b1, BNE_EN ? 3 : 2, 1, BNE_EN ? 0 : 1, 0};
    op_pool = '{LW, SW, RT, BEQ, ADDI, JMP, BNE, BAD, 6'b001101};
    fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    // Power-on reset: state FETCH, strobes held low even with memory ready.
    reset_ni = 1'b0; op_i6 = 6'd0; funct_i6 = 6'd0; zero_i = 1'b0; mem_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("reset_state", 32'(actual_word()),
            32'(expect_word(0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0)));
    end
    @(posedge clk_i); #1;
    reset_ni = 1'b1;

    // Latency and event counts per instruction with memory always ready.
    foreach (vecs[k]) begin
      op_i6 = vecs[k].op; funct_i6 = vecs[k].funct; zero_i = vecs[k].z;
      mem_ready_i = 1'b1;
      cnt = 0; pe = 0; il = 0; rw = 0;
      do begin
        @(negedge clk_i);
        pe += int'(pc_en_o); il += int'(illegal_op_o); rw += int'(reg_write_o);
        cnt++;
        @(posedge clk_i); #1;
      end while (state_o4 != 4'd0 && cnt < 20);
      check($sformatf("vec%0d_len", k), 32'(cnt), 32'(vecs[k].len));
      check($sformatf("vec%0d_pc_en", k), 32'(pe), 32'(vecs[k].pcen));
      check($sformatf("vec%0d_illegal", k), 32'(il), 32'(vecs[k].ill));
      check($sformatf("vec%0d_reg_write", k), 32'(rw), 32'(vecs[k].rw));
    end

    // lw trace 0,1,2,3,4,0 ; R-type slt ; beq taken/not taken ; illegal op.
    run_instr("lw_trace", LW, 6'b100000, 1'b0, 0, 0);
    run_instr("slt", RT, 6'b101010, 1'b0, 0, 0);
    run_instr("beq_taken", BEQ, 6'b000000, 1'b1, 0, 0);
    run_instr("beq_not", BEQ, 6'b000000, 1'b0, 0, 0);
    run_instr("illegal", BAD, 6'b000000, 1'b0, 0, 0);
    run_instr("bne", BNE, 6'b000000, 1'b0, 0, 0);

    // sw with three wait cycles: mem_write_o high for exactly four cycles.
    op_i6 = SW; mem_ready_i = 1'b1; wcnt = 0;
    repeat (3) begin @(posedge clk_i); #1; end
    mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready_i = 1'b1;
      @(negedge clk_i);
      wcnt += int'(mem_write_o);
      @(posedge clk_i); #1;
    end
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    check("sw_wait_count", 32'(wcnt), 32'd4);
    check("sw_wait_fetch", 32'(state_o4), 32'd0);

    // Reset while waiting in MEMWR: strobes forced low, FETCH after the edge.
    @(posedge clk_i); #1;
    op_i6 = SW; mem_ready_i = 1'b1;
    repeat (3) begin @(posedge clk_i); #1; end
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    check("memwr_before_reset", 32'(actual_word()),
          32'(expect_word(5, SW, 6'd0, 1'b0, 1'b0, 1'b1)));
    @(posedge clk_i); #1;
    reset_ni = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk_i);
    check("reset_memwr_c1", 32'(actual_word()),
          32'(expect_word(5, SW, 6'd0, 1'b0, 1'b1, 1'b0)));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("reset_memwr_c2", 32'(actual_word()),
          32'(expect_word(0, SW, 6'd0, 1'b0, 1'b1, 1'b0)));
    @(posedge clk_i); #1;
    reset_ni = 1'b1; mem_ready_i = 1'b0;
    @(negedge clk_i);
    check("reset_release", 32'(actual_word()),
          32'(expect_word(0, SW, 6'd0, 1'b0, 1'b0, 1'b1)));
    @(posedge clk_i); #1;

    // Random instruction stream with random fetch and memory waits.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] rop, rfn;
      rop = op_pool[$urandom_range(0, 8)];
      if ($urandom_range(0, 7) == 0) rop = 6'($urandom_range(0, 63));
      rfn = fn_pool[$urandom_range(0, 5)];
      run_instr($sformatf("rand%0d", i), rop, rfn, 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
